// File: rtl/pid_rx_sequencer.sv
// pid_rx_sequencer: per-packet controller for the USB receive PID checker.
// Pulses start_decode after sync, captures the PID byte, waits for the checker
// under a timeout, classifies the packet, counts payload bit-cycles up to EOP and
// closes each packet with a one-cycle end_PID / result_valid pulse.
// Optional feature: define PID_SEQ_STATS_EN to add per-class result counters
// (stats_clr, ack_cnt, nak_cnt, data_cnt, err_cnt).
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for sync_done
// S_DECODE  | shifting PID bits in, waiting for PID_checked / eop / timeout
// S_PAYLOAD | counting payload bit-cycles until eop or length violation
// S_RELEASE | one cycle: end_PID + result_valid, result outputs updated
module pid_rx_sequencer #(
    parameter int TIMEOUT_CYC  = 16,
    parameter int MAX_PAY_BITS = 8192,
    parameter int CW           = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sync_done,
    input  logic          s_in,
    input  logic          eop,
    input  logic          PID_checked,
    input  logic          PID_valid,
`ifdef PID_SEQ_STATS_EN
    input  logic          stats_clr,
    output logic [15:0]   ack_cnt,
    output logic [15:0]   nak_cnt,
    output logic [15:0]   data_cnt,
    output logic [15:0]   err_cnt,
`endif
    output logic          start_decode,
    output logic          end_PID,
    output logic          busy,
    output logic          result_valid,
    output logic [2:0]    result_code,
    output logic [CW-1:0] payload_bits
);

    // Timer must hold both TIMEOUT_CYC and the 8-bit capture window bound.
    localparam int TW = ($clog2(TIMEOUT_CYC + 1) > 4) ? $clog2(TIMEOUT_CYC + 1) : 4;

    localparam logic [2:0] C_ACK     = 3'd0;
    localparam logic [2:0] C_NAK     = 3'd1;
    localparam logic [2:0] C_DATA0   = 3'd2;
    localparam logic [2:0] C_DATA1   = 3'd3;
    localparam logic [2:0] C_ERR_PID = 3'd4;
    localparam logic [2:0] C_ERR_TO  = 3'd5;
    localparam logic [2:0] C_ERR_LEN = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_PAYLOAD,
        S_RELEASE
    } state_t;

    state_t          state;
    logic [TW-1:0]   timer;
    logic [7:0]      pid_sr;
    logic [2:0]      cls;
    logic [CW-1:0]   pay_cnt;

    logic            n_known;
    logic [2:0]      n_code;
    logic [CW-1:0]   cnt_inc;
    logic            len_over;
    logic            fin;
    logic [2:0]      fin_code;
    logic [CW-1:0]   fin_bits;
    logic            go_pay;

    // Map the low PID nibble to a packet class.
    always_comb begin
        n_known = 1'b1;
        n_code  = C_ACK;
        case (pid_sr[3:0])
            4'b0010: n_code = C_ACK;
            4'b1010: n_code = C_NAK;
            4'b0011: n_code = C_DATA0;
            4'b1011: n_code = C_DATA1;
            default: n_known = 1'b0;
        endcase
    end

    // Saturating payload increment and the length-limit test on the incremented value,
    // so a violation closes the packet on the very bit-cycle that exceeds the limit.
    always_comb begin
        cnt_inc  = (pay_cnt == {CW{1'b1}}) ? pay_cnt : pay_cnt + 1'b1;
        len_over = cls[1] ? (cnt_inc > CW'(MAX_PAY_BITS)) : (cnt_inc != '0);
    end

    // Decide whether this cycle terminates the packet and with which result.
    // In DECODE eop outranks PID_checked, which outranks the timeout.
    always_comb begin
        fin      = 1'b0;
        fin_code = C_ACK;
        fin_bits = '0;
        go_pay   = 1'b0;
        case (state)
            S_DECODE: begin
                if (eop) begin
                    fin      = 1'b1;
                    fin_code = C_ERR_PID;
                end else if (PID_checked) begin
                    if (PID_valid && n_known) begin
                        go_pay = 1'b1;
                    end else begin
                        fin      = 1'b1;
                        fin_code = C_ERR_PID;
                    end
                end else if (timer == TW'(TIMEOUT_CYC)) begin
                    fin      = 1'b1;
                    fin_code = C_ERR_TO;
                end
            end
            S_PAYLOAD: begin
                if (eop) begin
                    fin      = 1'b1;
                    fin_bits = pay_cnt;
                    fin_code = (cls[1] || pay_cnt == '0) ? cls : C_ERR_LEN;
                end else if (len_over) begin
                    fin      = 1'b1;
                    fin_bits = cnt_inc;
                    fin_code = C_ERR_LEN;
                end
            end
            default: ;
        endcase
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            timer        <= '0;
            pid_sr       <= '0;
            cls          <= C_ACK;
            pay_cnt      <= '0;
            start_decode <= 1'b0;
            end_PID      <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result_code  <= '0;
            payload_bits <= '0;
        end else begin
            start_decode <= 1'b0;
            end_PID      <= 1'b0;
            result_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sync_done) begin
                        state        <= S_DECODE;
                        start_decode <= 1'b1;
                        busy         <= 1'b1;
                        timer        <= '0;
                        pid_sr       <= '0;
                    end
                end
                S_DECODE: begin
                    if (timer < TW'(8)) begin
                        pid_sr <= {s_in, pid_sr[7:1]};
                    end
                    timer <= timer + 1'b1;
                    if (go_pay) begin
                        state   <= S_PAYLOAD;
                        cls     <= n_code;
                        pay_cnt <= '0;
                    end
                end
                S_PAYLOAD: begin
                    pay_cnt <= cnt_inc;
                end
                S_RELEASE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
            if (fin) begin
                state        <= S_RELEASE;
                end_PID      <= 1'b1;
                result_valid <= 1'b1;
                result_code  <= fin_code;
                payload_bits <= fin_bits;
            end
        end
    end

`ifdef PID_SEQ_STATS_EN
    // Per-class saturating result counters; clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_cnt  <= '0;
            nak_cnt  <= '0;
            data_cnt <= '0;
            err_cnt  <= '0;
        end else if (stats_clr) begin
            ack_cnt  <= '0;
            nak_cnt  <= '0;
            data_cnt <= '0;
            err_cnt  <= '0;
        end else if (result_valid) begin
            case (result_code)
                C_ACK:            if (ack_cnt  != 16'hFFFF) ack_cnt  <= ack_cnt  + 16'd1;
                C_NAK:            if (nak_cnt  != 16'hFFFF) nak_cnt  <= nak_cnt  + 16'd1;
                C_DATA0, C_DATA1: if (data_cnt != 16'hFFFF) data_cnt <= data_cnt + 16'd1;
                default:          if (err_cnt  != 16'hFFFF) err_cnt  <= err_cnt  + 16'd1;
            endcase
        end
    end
`endif

endmodule
